// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access engine.
//   MEM_SIZE_*   : encodings of the mem_size field (11 is reserved and behaves as a word)
//   mem_state_e  : access FSM states
//   be_of()      : little-endian byte enables for a size and the low two address bits
package mem_pkg;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
   localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
   localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
   localparam logic [1:0] MEM_SIZE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } mem_state_e;

   function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] be;
      case (size)
         MEM_SIZE_BYTE: be = 4'b0001 << addr_lo;
         MEM_SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:       be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access engine (master) and memory (slave).
//   bus_req   : master -> slave, request pending
//   bus_we    : master -> slave, 1 = write
//   bus_addr  : master -> slave, word-aligned byte address
//   bus_be    : master -> slave, little-endian byte enables
//   bus_wdata : master -> slave, lane-replicated write data (0 for reads)
//   bus_ack   : slave -> master, completion
//   bus_rdata : slave -> master, read data, valid only with bus_ack
//
// Handshake: the master raises bus_req with addr/be/we/wdata and holds all of them
// stable until it samples bus_ack=1 on a rising clk edge; that edge completes the
// transfer and bus_req is low the following cycle. The master may also withdraw a
// read (pipeline flush) or give up after a timeout by dropping bus_req without an
// ack; the slave must treat a dropped request as cancelled.
interface mem_access_unit_if;

   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req,
      output bus_we,
      output bus_addr,
      output bus_be,
      output bus_wdata,
      input  bus_ack,
      input  bus_rdata
   );

   modport slave (
      input  bus_req,
      input  bus_we,
      input  bus_addr,
      input  bus_be,
      input  bus_wdata,
      output bus_ack,
      output bus_rdata
   );

endinterface

// File: rtl/mem_store_align.sv
// Combinational lane steering for a data-memory access.
//   size          in  2   mem_size encoding
//   addr_lo       in  2   addr[1:0]
//   wdata         in  32  low-aligned store data
//   be            out 4   byte enables
//   wdata_aligned out 32  store data replicated across every lane the size can hit
//   misaligned    out 1   access crosses its natural boundary
module mem_store_align
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_aligned,
   output logic        misaligned
);

   // Replicating the data lets the memory pick its lane from be alone.
   always_comb begin
      be            = be_of(size, addr_lo);
      wdata_aligned = wdata;
      misaligned    = 1'b0;
      case (size)
         MEM_SIZE_BYTE: begin
            wdata_aligned = {4{wdata[7:0]}};
         end
         MEM_SIZE_HALF: begin
            wdata_aligned = {2{wdata[15:0]}};
            misaligned    = addr_lo[0];
         end
         MEM_SIZE_WORD, MEM_SIZE_RSVD: begin
            wdata_aligned = wdata;
            misaligned    = (addr_lo != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine sitting between EX_MEM and MEM_WB.
// Accepts the load/store held in EX_MEM, raises AdEL/AdES on misalignment, runs
// one bus transfer otherwise and stalls the pipeline until it completes.
//   clk, rst      in   clock, synchronous active-high reset
//   flush         in   flush of the MEM-stage instruction
//   req_valid     in   EX_MEM holds a load/store
//   mem_we        in   1 = store
//   mem_size      in   access size (see mem_pkg)
//   addr, wdata   in   byte address, low-aligned store data
//   stall         out  hold the front of the pipe, bubble MEM_WB
//   done          out  one-cycle pulse, rdata valid
//   rdata         out  raw word from the bus (extension happens in WB)
//   adel, ades    out  one-cycle misaligned load/store pulses
//   bus_err       out  one-cycle pulse with done after a bus timeout
//   bus           master side of the data bus
//   fsm_state     out  current FSM state (observability)
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              req_valid,
   input  logic              mem_we,
   input  logic [1:0]        mem_size,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              stall,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              adel,
   output logic              ades,
   output logic              bus_err,
   mem_access_unit_if.master bus,
   output mem_state_e        fsm_state
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   // The counter equals the number of BUS cycles already spent, so the cycle in
   // which it reads TIMEOUT_CYCLES-1 is the last one bus_req may be high.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   mem_state_e       state;
   mem_state_e       state_d;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_d;

   logic [31:0] addr_q;
   logic [3:0]  be_q;
   logic        we_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        store_flushed_q;

   logic [3:0]  align_be;
   logic [31:0] align_wdata;
   logic        misaligned;

   logic accept;
   logic set_flushed;
   logic capture_rdata;
   logic clear_rdata;
   logic set_err;
   logic flushed_now;
   logic idle_req;

   mem_store_align u_align (
      .size          (mem_size),
      .addr_lo       (addr[1:0]),
      .wdata         (wdata),
      .be            (align_be),
      .wdata_aligned (align_wdata),
      .misaligned    (misaligned)
   );

   // ---------------------------------------------------------------- FSM state
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // ------------------------------------------------- next state and controls
   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      accept        = 1'b0;
      set_flushed   = 1'b0;
      capture_rdata = 1'b0;
      clear_rdata   = 1'b0;
      set_err       = 1'b0;
      // A store flushed earlier in BUS, or right now, still finishes on the bus
      // but must not report completion to the pipeline.
      flushed_now   = store_flushed_q | flush;
      case (state)
         IDLE: begin
            if (req_valid && !flush && !misaligned) begin
               accept  = 1'b1;
               cnt_d   = '0;
               state_d = BUS;
            end
         end
         BUS: begin
            cnt_d       = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
            set_flushed = flush;
            if (flush && !we_q) begin
               // Abandoned load: flush beats a coincident ack.
               state_d = IDLE;
            end else if (bus.bus_ack) begin
               // Ack beats a coincident timeout.
               capture_rdata = !we_q;
               state_d       = flushed_now ? IDLE : DONE;
            end else if (cnt == CNT_LAST) begin
               if (flushed_now) begin
                  state_d = IDLE;
               end else begin
                  set_err     = 1'b1;
                  clear_rdata = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------ datapath and bus registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt             <= '0;
         addr_q          <= '0;
         be_q            <= '0;
         we_q            <= 1'b0;
         wdata_q         <= '0;
         rdata_q         <= '0;
         err_q           <= 1'b0;
         store_flushed_q <= 1'b0;
      end else begin
         cnt <= cnt_d;
         if (accept) begin
            addr_q          <= {addr[31:2], 2'b00};
            be_q            <= align_be;
            we_q            <= mem_we;
            wdata_q         <= mem_we ? align_wdata : 32'h0;
            err_q           <= 1'b0;
            store_flushed_q <= 1'b0;
         end
         if (set_flushed) begin
            store_flushed_q <= 1'b1;
         end
         if (set_err) begin
            err_q <= 1'b1;
         end
         if (capture_rdata) begin
            rdata_q <= bus.bus_rdata;
         end else if (clear_rdata) begin
            rdata_q <= '0;
         end
      end
   end

   // ------------------------------------------------------------------ outputs
   // Pipeline-facing pulses are masked during reset so nothing escapes that cycle.
   assign idle_req = (state == IDLE) && req_valid && !flush;

   assign stall   = !rst && ((idle_req && !misaligned) || (state == BUS));
   assign adel    = !rst && idle_req && misaligned && !mem_we;
   assign ades    = !rst && idle_req && misaligned && mem_we;
   assign done    = !rst && (state == DONE);
   assign bus_err = !rst && (state == DONE) && err_q;
   assign rdata   = rdata_q;

   assign bus.bus_req   = (state == BUS);
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_be    = be_q;
   assign bus.bus_wdata = wdata_q;

   assign fsm_state = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: drives EX_MEM-side requests and plays the
// bus slave; expected rdata values go into a queue when a request is issued and
// are popped when done pulses.
`timescale 1ns/1ps
module tb_mem_access_unit;
   import mem_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        req_valid;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic        done;
   logic [31:0] rdata;
   logic        adel;
   logic        ades;
   logic        bus_err;
   mem_state_e  fsm_state;

   mem_access_unit_if bus_if ();

   mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .req_valid (req_valid),
      .mem_we    (mem_we),
      .mem_size  (mem_size),
      .addr      (addr),
      .wdata     (wdata),
      .stall     (stall),
      .done      (done),
      .rdata     (rdata),
      .adel      (adel),
      .ades      (ades),
      .bus_err   (bus_err),
      .bus       (bus_if),
      .fsm_state (fsm_state)
   );

   // ------------------------------------------------------------ clock / reset
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- scoreboard
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Inputs change 1ns after the rising edge; outputs are read 1ns later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------ driver tasks
   // ack_wait = number of BUS cycles before the one carrying bus_ack (>= TO: never).
   task automatic access(input logic we, input logic [1:0] size, input logic [31:0] a,
                         input logic [31:0] wd, input int ack_wait, input logic [31:0] rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input string tag);
      int          bus_cycles;
      int          stall_cycles;
      int          exp_bus;
      bit          got;
      bit          exp_err;
      logic [31:0] exp_rd;
      exp_err = (ack_wait >= TO);
      exp_bus = exp_err ? TO : ack_wait + 1;
      exp_rd  = exp_err ? 32'h0 : (we ? last_rdata : rd);
      exp_q.push_back(exp_rd);
      last_rdata = exp_rd;

      next_cycle();
      req_valid = 1'b1; mem_we = we; mem_size = size; addr = a; wdata = wd; flush = 1'b0;
      bus_if.bus_ack = 1'b0;
      #1;
      stall_cycles = int'(stall);
      bus_cycles   = 0;
      got          = 1'b0;
      for (int c = 0; c < TO + 8 && !got; c++) begin
         next_cycle();
         bus_if.bus_ack   = (c == ack_wait);
         bus_if.bus_rdata = (c == ack_wait) ? rd : $urandom;
         #1;
         if (done) begin
            got = 1'b1;
            check({tag, "_done_stall"}, stall, 0);
            check({tag, "_done_busreq"}, bus_if.bus_req, 0);
            check({tag, "_bus_err"}, bus_err, exp_err);
            if (exp_q.size() > 0) check({tag, "_rdata"}, rdata, exp_q.pop_front());
            else check({tag, "_sb_underflow"}, 1, 0);
         end else begin
            if (c == 0) begin
               check({tag, "_bus_addr"}, bus_if.bus_addr, {a[31:2], 2'b00});
               check({tag, "_bus_be"}, bus_if.bus_be, exp_be);
               check({tag, "_bus_we"}, bus_if.bus_we, we);
               check({tag, "_bus_wdata"}, bus_if.bus_wdata, exp_wdata);
            end
            bus_cycles   += int'(bus_if.bus_req);
            stall_cycles += int'(stall);
         end
      end
      bus_if.bus_ack = 1'b0;
      if (!got) check({tag, "_done_seen"}, 0, 1);
      check({tag, "_busreq_cycles"}, bus_cycles, exp_bus);
      check({tag, "_stall_cycles"}, stall_cycles, exp_bus + 1);
      next_cycle();
      req_valid = 1'b0;
      #1;
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_back_idle"}, fsm_state, IDLE);
   endtask

   task automatic misalign(input logic we, input logic [1:0] size, input logic [31:0] a,
                           input string tag);
      next_cycle();
      req_valid = 1'b1; mem_we = we; mem_size = size; addr = a; wdata = 32'h0; flush = 1'b0;
      #1;
      check({tag, "_adel"}, adel, !we);
      check({tag, "_ades"}, ades, we);
      check({tag, "_stall"}, stall, 0);
      next_cycle();
      req_valid = 1'b0;
      #1;
      check({tag, "_busreq"}, bus_if.bus_req, 0);
      check({tag, "_exc_pulse"}, {adel, ades}, 0);
      check({tag, "_idle"}, fsm_state, IDLE);
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      logic [31:0] rnd;
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; mem_we = 1'b0; mem_size = MEM_SIZE_WORD;
      addr = 32'h0; wdata = 32'h0; bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
      last_rdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_stall", stall, 0);
      check("rst_done", done, 0);
      check("rst_rdata", rdata, 0);
      check("rst_exc", {adel, ades, bus_err}, 0);
      check("rst_busreq", bus_if.bus_req, 0);
      check("rst_bus_addr", bus_if.bus_addr, 0);
      check("rst_bus_be", bus_if.bus_be, 0);
      check("rst_bus_wdata", bus_if.bus_wdata, 0);
      check("rst_state", fsm_state, IDLE);

      // Basic loads/stores of each size.
      access(1'b0, MEM_SIZE_WORD, 32'h0000_1000, 32'h0, 1, 32'hDEAD_BEEF, 4'b1111, 32'h0, "lw");
      access(1'b1, MEM_SIZE_BYTE, 32'h0000_1003, 32'h0000_00A5, 0, 32'h1357_9BDF,
             4'b1000, 32'hA5A5_A5A5, "sb");
      rnd = $urandom;
      access(1'b0, MEM_SIZE_BYTE, 32'h0000_1001, 32'h0, $urandom_range(1, 4), rnd,
             4'b0010, 32'h0, "lb");
      access(1'b1, MEM_SIZE_HALF, 32'h0000_1002, 32'hFFFF_1234, 2, 32'h0,
             4'b1100, 32'h1234_1234, "sh");
      rnd = $urandom;
      access(1'b0, MEM_SIZE_HALF, 32'h0000_2000, 32'h0, 0, rnd, 4'b0011, 32'h0, "lh");
      access(1'b1, MEM_SIZE_RSVD, 32'h0000_1004, 32'hCAFE_F00D, 0, 32'h0,
             4'b1111, 32'hCAFE_F00D, "sw_rsvd");

      // Misaligned accesses.
      misalign(1'b0, MEM_SIZE_HALF, 32'h0000_1001, "lh_mis");
      misalign(1'b1, MEM_SIZE_WORD, 32'h0000_1002, "sw_mis");

      // Timeout, and ack arriving in the last permitted cycle.
      access(1'b0, MEM_SIZE_WORD, 32'h0000_2000, 32'h0, 100, 32'h1111_1111,
             4'b1111, 32'h0, "timeout");
      access(1'b0, MEM_SIZE_WORD, 32'h0000_2004, 32'h0, TO - 1, 32'h2468_ACE0,
             4'b1111, 32'h0, "ack_at_limit");

      // Flush while still in IDLE: nothing issued, no exception.
      next_cycle();
      req_valid = 1'b1; flush = 1'b1; mem_we = 1'b0; mem_size = MEM_SIZE_HALF; addr = 32'h0000_1001;
      #1;
      check("idle_flush_mis_adel", adel, 0);
      check("idle_flush_stall", stall, 0);
      next_cycle();
      mem_size = MEM_SIZE_WORD; addr = 32'h0000_3000;
      #1;
      check("idle_flush_al_stall", stall, 0);
      next_cycle();
      req_valid = 1'b0; flush = 1'b0;
      #1;
      check("idle_flush_busreq", bus_if.bus_req, 0);

      // Load flushed one cycle into BUS: abandoned.
      next_cycle();
      req_valid = 1'b1; mem_we = 1'b0; mem_size = MEM_SIZE_WORD; addr = 32'h0000_3000;
      #1;
      check("fl_ld_accept", stall, 1);
      next_cycle();
      flush = 1'b1;
      #1;
      check("fl_ld_busreq_in_bus", bus_if.bus_req, 1);
      next_cycle();
      flush = 1'b0; req_valid = 1'b0;
      #1;
      check("fl_ld_busreq_drop", bus_if.bus_req, 0);
      check("fl_ld_no_done", done, 0);
      check("fl_ld_idle", fsm_state, IDLE);
      next_cycle();
      check("fl_ld_no_done_later", done, 0);

      // Flush coinciding with ack on a load: flush wins.
      next_cycle();
      req_valid = 1'b1; mem_we = 1'b0; mem_size = MEM_SIZE_WORD; addr = 32'h0000_3008;
      next_cycle();
      flush = 1'b1; bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h5555_AAAA;
      next_cycle();
      flush = 1'b0; req_valid = 1'b0; bus_if.bus_ack = 1'b0;
      #1;
      check("fl_ack_no_done", done, 0);
      check("fl_ack_rdata_kept", rdata, last_rdata);
      check("fl_ack_idle", fsm_state, IDLE);

      // Store flushed one cycle into BUS: held until ack, then silent.
      next_cycle();
      req_valid = 1'b1; mem_we = 1'b1; mem_size = MEM_SIZE_WORD; addr = 32'h0000_3004;
      wdata = 32'h0BAD_F00D;
      next_cycle();
      flush = 1'b1;
      #1;
      check("fl_st_busreq_0", bus_if.bus_req, 1);
      next_cycle();
      flush = 1'b0; req_valid = 1'b0;
      #1;
      check("fl_st_busreq_1", bus_if.bus_req, 1);
      check("fl_st_wdata_held", bus_if.bus_wdata, 32'h0BAD_F00D);
      next_cycle();
      bus_if.bus_ack = 1'b1;
      #1;
      check("fl_st_busreq_2", bus_if.bus_req, 1);
      next_cycle();
      bus_if.bus_ack = 1'b0;
      #1;
      check("fl_st_busreq_drop", bus_if.bus_req, 0);
      check("fl_st_no_done", {done, bus_err}, 0);
      check("fl_st_idle", fsm_state, IDLE);
      check("fl_st_rdata_kept", rdata, last_rdata);

      // Reset in the middle of a bus access.
      next_cycle();
      req_valid = 1'b1; mem_we = 1'b0; mem_size = MEM_SIZE_WORD; addr = 32'h0000_4000;
      next_cycle();
      #1;
      check("rst_mid_busreq_before", bus_if.bus_req, 1);
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0; req_valid = 1'b0;
      #1;
      last_rdata = 32'h0;
      check("rst_mid_busreq", bus_if.bus_req, 0);
      check("rst_mid_bus_addr", bus_if.bus_addr, 0);
      check("rst_mid_bus_be", bus_if.bus_be, 0);
      check("rst_mid_done", {done, bus_err}, 0);
      check("rst_mid_rdata", rdata, 0);
      check("rst_mid_state", fsm_state, IDLE);
      next_cycle();
      check("rst_mid_no_done", done, 0);
      access(1'b0, MEM_SIZE_WORD, 32'h0000_4000, 32'h0, 1, 32'h0F0F_1234, 4'b1111, 32'h0, "post_rst_lw");

      check("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
